// File: rtl/fp_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_cmp_arbiter (with helper fp_cmp_unit)
// Description : Two-requester round-robin front end for a single IEEE-754
//               single-precision compare unit.
//               Supported ops:
//                 - FLE, FLT and FEQ.
//                 - FMIN and FMAX, only when the macro FP_CMP_MINMAX_EN is
//                   defined. Without it, ops 100/101 are reserved.
//               Each request goes through IDLE -> WAIT (LAT cycles) -> RESP,
//               and the response is held until the consumer takes it.
//               A sticky NV flag collects invalid-operation events.
// Parameters  : LAT  compare settle cycles, legal range 1..4
// Ports       : clk, rst (async, active-high)
//               req0_*/req1_* : valid/ready, a, b (32b), op (3b)
//               rsp_valid/rsp_ready, rsp_id, rsp_data (32b), rsp_nv
//               fflags_nv (sticky NV), clr_nv (clear sticky NV)
// Config      : `define FP_CMP_MINMAX_EN enables FMIN/FMAX
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// fp_cmp_unit: combinational single-precision comparator.
//   rm 00 = LE, 01 = LT, 10 = EQ, 11 = no result.
//   LE/LT are signaling compares (any NaN raises invalid).
//   EQ is quiet (only sNaN raises invalid).
//   Any NaN forces s = 0.
// ----------------------------------------------------------------------------
module fp_cmp_unit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic        s,
    output logic        invalid
);
    logic w_a_nan;
    logic w_b_nan;
    logic w_any_nan;
    logic w_any_snan;
    logic w_both_zero;
    logic w_eq;
    logic w_lt;

    assign w_a_nan     = (&a[30:23]) && (|a[22:0]);
    assign w_b_nan     = (&b[30:23]) && (|b[22:0]);
    assign w_any_nan   = w_a_nan || w_b_nan;
    assign w_any_snan  = (w_a_nan && !a[22]) || (w_b_nan && !b[22]);
    assign w_both_zero = (~|a[30:0]) && (~|b[30:0]);

    // +0 and -0 compare equal
    assign w_eq = !w_any_nan && ((a == b) || w_both_zero);

    // Sign-magnitude ordering; negative magnitudes order in reverse
    always_comb begin
        w_lt = 1'b0;
        if (w_any_nan) begin
            w_lt = 1'b0;
        end else if (a[31] != b[31]) begin
            w_lt = a[31] && !w_both_zero;
        end else if (!a[31]) begin
            w_lt = (a[30:0] < b[30:0]);
        end else begin
            w_lt = (b[30:0] < a[30:0]);
        end
    end

    always_comb begin
        s       = 1'b0;
        invalid = 1'b0;
        case (rm)
            2'b00: begin
                s       = w_lt || w_eq;
                invalid = w_any_nan;
            end
            2'b01: begin
                s       = w_lt;
                invalid = w_any_nan;
            end
            2'b10: begin
                s       = w_eq;
                invalid = w_any_snan;
            end
            default: begin
                s       = 1'b0;
                invalid = 1'b0;
            end
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
// fp_cmp_arbiter: top level
// ----------------------------------------------------------------------------
module fp_cmp_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_nv,
    output logic        fflags_nv,
    input  logic        clr_nv
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Two bits cover the LAT-1 range 0..3
    localparam logic [1:0] c_cnt_init = 2'(LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic        r_id;
    logic        r_last_id;

    logic        w_any_valid;
    logic        w_grant_id;
    logic        w_accept;
    logic [1:0]  w_rm;
    logic        w_cmp_s;
    logic        w_cmp_invalid;
    logic [31:0] w_res_data;
    logic        w_res_nv;

    // Round-robin only matters on a tie; a lone requester always wins
    assign w_any_valid = req0_valid || req1_valid;
    assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_id : req1_valid;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs.
    // Ready is gated by rst so nothing is offered while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid && !rst) begin
                    req0_ready  = !w_grant_id;
                    req1_ready  = w_grant_id;
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rsp_valid = (r_state == S_RESP);

    // ------------------------------------------------------------------
    // Compare unit, fed from the latched operands.
    // Min/max reuse the LT relation.
    // ------------------------------------------------------------------
    assign w_rm = r_op[2] ? 2'b01 : r_op[1:0];

    fp_cmp_unit u_cmp (
        .a       (r_a),
        .b       (r_b),
        .rm      (w_rm),
        .s       (w_cmp_s),
        .invalid (w_cmp_invalid)
    );

`ifdef FP_CMP_MINMAX_EN
    logic w_a_nan;
    logic w_b_nan;
    logic w_a_snan;
    logic w_b_snan;
    logic w_both_zero;

    assign w_a_nan     = (&r_a[30:23]) && (|r_a[22:0]);
    assign w_b_nan     = (&r_b[30:23]) && (|r_b[22:0]);
    assign w_a_snan    = w_a_nan && !r_a[22];
    assign w_b_snan    = w_b_nan && !r_b[22];
    assign w_both_zero = (~|r_a[30:0]) && (~|r_b[30:0]);
`endif

    always_comb begin
        w_res_data = 32'h0000_0000;
        w_res_nv   = 1'b0;
        case (r_op)
            3'b000, 3'b001, 3'b010: begin
                w_res_data = {31'b0, w_cmp_s};
                w_res_nv   = w_cmp_invalid;
            end
`ifdef FP_CMP_MINMAX_EN
            3'b100, 3'b101: begin
                w_res_nv = w_a_snan || w_b_snan;
                if (w_a_nan && w_b_nan) begin
                    w_res_data = 32'h7FC0_0000;
                end else if (w_a_nan) begin
                    w_res_data = r_b;
                end else if (w_b_nan) begin
                    w_res_data = r_a;
                end else if (w_both_zero) begin
                    // Signed zeros: min prefers -0, max prefers +0
                    w_res_data = r_op[0] ? {r_a[31] & r_b[31], 31'b0}
                                         : {r_a[31] | r_b[31], 31'b0};
                end else begin
                    // op[0] = 0 is FMIN (take a when a<b), 1 is FMAX
                    w_res_data = (w_cmp_s ^ r_op[0]) ? r_a : r_b;
                end
            end
`endif
            default: begin
                w_res_data = 32'h0000_0000;
                w_res_nv   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, settle counter, response hold, sticky NV
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_a       <= 32'h0000_0000;
            r_b       <= 32'h0000_0000;
            r_op      <= 3'b000;
            r_id      <= 1'b0;
            r_last_id <= 1'b1;
            rsp_id    <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_nv    <= 1'b0;
            fflags_nv <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a       <= w_grant_id ? req1_a  : req0_a;
                r_b       <= w_grant_id ? req1_b  : req0_b;
                r_op      <= w_grant_id ? req1_op : req0_op;
                r_id      <= w_grant_id;
                r_last_id <= w_grant_id;
                r_cnt     <= c_cnt_init;
            end

            if (r_state == S_WAIT) begin
                if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end else begin
                    rsp_data <= w_res_data;
                    rsp_nv   <= w_res_nv;
                    rsp_id   <= r_id;
                end
            end

            // Set has priority over a coincident clear
            if (rsp_valid && rsp_ready && rsp_nv) begin
                fflags_nv <= 1'b1;
            end else if (clr_nv) begin
                fflags_nv <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_cmp_arbiter
// Description : Directed self-checking bench for fp_cmp_arbiter.
//               Two instances share the inputs:
//                 - u_dut1 uses LAT=1 and is the main checked instance.
//                 - u_dut3 uses LAT=3 and is checked only for the
//                   reset-during-WAIT and latency scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_cmp_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic [2:0]  req0_op = '0;
    logic [2:0]  req1_op = '0;
    logic        rsp_ready = 1'b0;
    logic        clr_nv = 1'b0;

    logic        d1_req0_ready, d1_req1_ready, d1_rsp_valid, d1_rsp_id, d1_rsp_nv, d1_fflags_nv;
    logic [31:0] d1_rsp_data;
    logic        d3_req0_ready, d3_req1_ready, d3_rsp_valid, d3_rsp_id, d3_rsp_nv, d3_fflags_nv;
    logic [31:0] d3_rsp_data;

`ifdef FP_CMP_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_cmp_arbiter #(.LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d1_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(d1_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id),
        .rsp_data(d1_rsp_data), .rsp_nv(d1_rsp_nv),
        .fflags_nv(d1_fflags_nv), .clr_nv(clr_nv)
    );

    fp_cmp_arbiter #(.LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d3_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(d3_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d3_rsp_id),
        .rsp_data(d3_rsp_data), .rsp_nv(d3_rsp_nv),
        .fflags_nv(d3_fflags_nv), .clr_nv(clr_nv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        if (!port) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge after acceptance
    task automatic send(input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input string tag);
        drive(port, a, b, op);
        #1;
        check({tag, ":ready"}, port ? d1_req1_ready : d1_req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Counts clock edges from acceptance until rsp_valid, bounded
    task automatic wait_rsp(input bit use3, input int exp_edges, input string tag);
        int n;
        n = 0;
        while (((use3 ? d3_rsp_valid : d1_rsp_valid) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, n, exp_edges);
    endtask

    task automatic finish_rsp(input bit use3, input string tag, input logic exp_id,
                              input logic [31:0] exp_data, input logic exp_nv);
        check({tag, ":id"},   use3 ? d3_rsp_id   : d1_rsp_id,   exp_id);
        check({tag, ":data"}, use3 ? d3_rsp_data : d1_rsp_data, exp_data);
        check({tag, ":nv"},   use3 ? d3_rsp_nv   : d1_rsp_nv,   exp_nv);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ":valid_drop"}, use3 ? d3_rsp_valid : d1_rsp_valid, 0);
    endtask

    task automatic do_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] exp_data,
                         input logic exp_nv, input string tag);
        send(port, a, b, op, tag);
        wait_rsp(1'b0, 1, tag);
        finish_rsp(1'b0, tag, port, exp_data, exp_nv);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_flag();
        clr_nv = 1'b1;
        @(negedge clk);
        clr_nv = 1'b0;
    endtask

    initial begin
        int seen;

        // Reset state: ready must stay low while rst is high
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 32'h4020_0000, 32'h4020_0000, 3'b010);
        #1;
        check("rst:req0_ready", d1_req0_ready, 0);
        check("rst:rsp_valid",  d1_rsp_valid, 0);
        check("rst:rsp_id",     d1_rsp_id, 0);
        check("rst:rsp_data",   d1_rsp_data, 0);
        check("rst:rsp_nv",     d1_rsp_nv, 0);
        check("rst:fflags",     d1_fflags_nv, 0);
        check("rst:d3_valid",   d3_rsp_valid, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // FEQ 2.5 == 2.5 on req0
        do_op(1'b0, 32'h4020_0000, 32'h4020_0000, 3'b010, 32'd1, 1'b0, "feq_eq");

        // Tie from reset: req0 first, then req1
        pulse_rst();
        drive(1'b0, 32'h4020_0000, 32'h3FC0_0000, 3'b000);
        drive(1'b1, 32'h3FC0_0000, 32'h4020_0000, 3'b001);
        #1;
        check("tie0:req0_ready", d1_req0_ready, 1);
        check("tie0:req1_ready", d1_req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("tie0:wait_no_ready", d1_req1_ready, 0);
        wait_rsp(1'b0, 1, "tie0");
        check("tie0:resp_no_ready", d1_req1_ready, 0);
        finish_rsp(1'b0, "tie0", 1'b0, 32'd0, 1'b0);
        #1;
        check("tie1:req1_ready", d1_req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(1'b0, 1, "tie1");
        finish_rsp(1'b0, "tie1", 1'b1, 32'd1, 1'b0);

        // Second tie after req1 was served: req0 wins; FLT -1.0 < 1.5
        drive(1'b0, 32'hBF80_0000, 32'h3FC0_0000, 3'b001);
        drive(1'b1, 32'h3FC0_0000, 32'h4020_0000, 3'b001);
        #1;
        check("rr:req0_ready", d1_req0_ready, 1);
        check("rr:req1_ready", d1_req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(1'b0, 1, "rr");
        finish_rsp(1'b0, "rr", 1'b0, 32'd1, 1'b0);

        // Lone req0 again right after req0 won; FEQ -0 == +0
        do_op(1'b0, 32'h8000_0000, 32'h0000_0000, 3'b010, 32'd1, 1'b0, "feq_zero");

        // FLT with sNaN, response held while rsp_ready stays low
        send(1'b0, 32'h7F80_0001, 32'h3FC0_0000, 3'b001, "snan");
        wait_rsp(1'b0, 1, "snan");
        for (int i = 0; i < 3; i++) begin
            check("snan:hold_valid", d1_rsp_valid, 1);
            check("snan:hold_data",  d1_rsp_data, 0);
            check("snan:hold_nv",    d1_rsp_nv, 1);
            check("snan:flag_pre",   d1_fflags_nv, 0);
            @(negedge clk);
        end
        finish_rsp(1'b0, "snan", 1'b0, 32'd0, 1'b1);
        check("snan:flag_set", d1_fflags_nv, 1);
        clear_flag();
        check("snan:flag_clr", d1_fflags_nv, 0);

        // Set beats a coincident clear
        send(1'b0, 32'hFF80_0001, 32'h3FC0_0000, 3'b000, "setwin");
        wait_rsp(1'b0, 1, "setwin");
        clr_nv = 1'b1;
        finish_rsp(1'b0, "setwin", 1'b0, 32'd0, 1'b1);
        clr_nv = 1'b0;
        check("setwin:flag", d1_fflags_nv, 1);
        clear_flag();

        // Quiet compare on qNaN: no invalid; signaling compare on qNaN: invalid
        do_op(1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 3'b010, 32'd0, 1'b0, "feq_qnan");
        do_op(1'b0, 32'h7FC0_0000, 32'h3FC0_0000, 3'b000, 32'd0, 1'b1, "fle_qnan");
        check("fle_qnan:flag", d1_fflags_nv, 1);
        clear_flag();

        // Min/max (results zero when the feature is compiled out)
        do_op(1'b0, 32'h8000_0000, 32'h0000_0000, 3'b100,
              MM ? 32'h8000_0000 : 32'h0, 1'b0, "fmin_zero");
        do_op(1'b1, 32'h7FC0_0000, 32'h3FC0_0000, 3'b101,
              MM ? 32'h3FC0_0000 : 32'h0, 1'b0, "fmax_qnan");
        do_op(1'b0, 32'h3FC0_0000, 32'h4020_0000, 3'b100,
              MM ? 32'h3FC0_0000 : 32'h0, 1'b0, "fmin_num");
        do_op(1'b0, 32'hBF80_0000, 32'h3FC0_0000, 3'b101,
              MM ? 32'h3FC0_0000 : 32'h0, 1'b0, "fmax_num");
        do_op(1'b0, 32'h7F80_0001, 32'h4020_0000, 3'b100,
              MM ? 32'h4020_0000 : 32'h0, MM, "fmin_snan");
        do_op(1'b0, 32'h7FC0_0000, 32'h7F80_0001, 3'b101,
              MM ? 32'h7FC0_0000 : 32'h0, MM, "fmax_2nan");
        clear_flag();

        // Reserved ops
        do_op(1'b0, 32'h3FC0_0000, 32'h4020_0000, 3'b011, 32'd0, 1'b0, "rsvd3");
        do_op(1'b1, 32'h7F80_0001, 32'h4020_0000, 3'b110, 32'd0, 1'b0, "rsvd6");

        // LAT=3: reset in WAIT drops the op; the next one completes in 3 edges
        pulse_rst();
        send(1'b0, 32'h4020_0000, 32'h4020_0000, 3'b010, "l3a");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("l3:rst_valid", d3_rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d3_rsp_valid === 1'b1) seen = 1;
        end
        check("l3:dropped", seen, 0);
        send(1'b1, 32'h3FC0_0000, 32'h4020_0000, 3'b001, "l3b");
        wait_rsp(1'b1, 3, "l3b");
        finish_rsp(1'b1, "l3b", 1'b1, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/fp_cmp_arbiter.md
FP_CMP_ARBITER -- requirements
Module: fp_cmp_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning compare-unit settle cycles; legal range 1..4.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  request present.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-007 SHALL have ports req0_op/req1_op  input  3  000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX, others reserved.
REQ-008 SHALL have port rsp_valid  output  1  response held.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_id  output  1  requester owning response.
REQ-011 SHALL have port rsp_data  output  32  result; bit 0 for compares, upper bits 0.
REQ-012 SHALL have port rsp_nv  output  1  invalid flag of this response.
REQ-013 SHALL have ports fflags_nv  output  1 (sticky NV) and clr_nv  input  1 (clear sticky).

Function
REQ-014 SHALL instantiate exactly one compare unit (inputs a, b, rm; outputs s, Invalid), driven from registered operands; rm = op[1:0] for FLE/FLT/FEQ, rm = 01 (LT) for FMIN/FMAX.
REQ-015 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-016 IDLE: grant one valid requester combinationally, assert only its reqN_ready; acceptance = valid && ready; latch a, b, op, id; go WAIT with cnt = LAT-1.
REQ-017 Both valid in IDLE: grant the requester not granted last (round-robin); single valid: grant it regardless of history.
REQ-018 WAIT: decrement cnt; at cnt == 0 capture result and NV, go RESP; rsp_valid rises LAT edges after the acceptance edge.
REQ-019 RESP: hold rsp_valid, rsp_id, rsp_data, rsp_nv stable until rsp_ready; on rsp_valid && rsp_ready go IDLE; no new request is accepted in WAIT or RESP.
REQ-020 FLE/FLT/FEQ: rsp_data = {31'b0, s[0]}, rsp_nv = Invalid.
REQ-021 FMIN/FMAX: both NaN -> 32'h7FC00000; one NaN -> the other operand; else FMIN returns a if a<b else b and FMAX the converse; -0 vs +0: FMIN 32'h80000000, FMAX 32'h00000000; rsp_nv = either operand sNaN (exp all ones, frac != 0, bit22 = 0).
REQ-022 Reserved op: rsp_data 0, rsp_nv 0, full handshake still completed.
REQ-023 fflags_nv sets on the rsp handshake edge when rsp_nv = 1; clr_nv clears it; simultaneous set and clear: set wins.

Reset
REQ-024 rst SHALL force state IDLE, cnt 0, last-grant = req1 (req0 wins first tie), rsp_valid 0, rsp_id 0, rsp_data 0, rsp_nv 0, fflags_nv 0, reqN_ready 0 while rst high.
REQ-025 rst asserted in WAIT or RESP SHALL drop the in-flight operation without a response.

Configuration
REQ-026 Macro FP_CMP_MINMAX_EN: defined -> FMIN/FMAX per REQ-021; undefined -> ops 100/101 treated as reserved per REQ-022 and the min/max select and NaN logic are absent.

Verification
REQ-027 LAT=1, req0 FEQ a=b=32'h40200000 -> rsp_valid 1 edge after accept, rsp_id 0, rsp_data 1, rsp_nv 0.
REQ-028 req0 FLE a=40200000 b=3FC00000 and req1 FLT a=3FC00000 b=40200000 both valid from reset -> req0 served first (data 0), then req1 (data 1).
REQ-029 FLT a=32'h7F800001 b=3FC00000, rsp_ready low 3 cycles -> outputs stable, data 0, rsp_nv 1, fflags_nv 1 after handshake; clr_nv pulse -> 0.
REQ-030 Macro defined: FMIN a=80000000 b=00000000 -> 80000000; FMAX a=7FC00000 b=3FC00000 -> 3FC00000, rsp_nv 0; macro undefined: same ops -> data 0.
REQ-031 LAT=3, rst pulsed during WAIT -> no rsp_valid, next request completes normally with LAT=3 timing.
